// File: rtl/alu_result_serializer.sv
// alu_result_serializer
// Captures an ALU result word on its valid strobe and hands it to the UART
// transmitter one byte at a time, least-significant byte first, using a
// valid/busy handshake. Ready tells the controller when a new result can be
// accepted.
//
// Optional feature: define ALU_SER_OVERRUN_FLAG_EN to add a sticky Overrun
// output that flags any result strobed in while the serializer was busy.
module alu_result_serializer #(
  parameter int Result_width = 16,
  parameter int Byte_width   = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [Result_width-1:0] ALU_Out,
  input  logic                    ALU_Out_Valid,
  input  logic                    Tx_Busy,
  output logic [Byte_width-1:0]   Tx_Data,
  output logic                    Tx_Data_Valid,
  output logic                    Ready
`ifdef ALU_SER_OVERRUN_FLAG_EN
  ,
  output logic                    Overrun
`endif
);

  localparam int NB = Result_width / Byte_width;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [Result_width-1:0] hold_q;
  logic [CW-1:0]           cnt_q;
  logic [Byte_width-1:0]   tx_data_q;
  logic                    tx_valid_q;
  logic                    ready_q;

  // Byte lanes of the holding register, lane 0 is the least-significant byte
  logic [Byte_width-1:0]   lane [NB];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign lane[gi] = hold_q[gi*Byte_width +: Byte_width];
    end
  endgenerate

  // Handshake FSM; every output comes straight from a register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      // The start strobe is a single-cycle pulse unless LOAD re-arms it
      tx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ALU_Out_Valid) begin
            hold_q  <= ALU_Out;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          // Never start a frame while the transmitter is still busy
          if (!Tx_Busy) begin
            tx_data_q  <= lane[cnt_q];
            tx_valid_q <= 1'b1;
            state_q    <= WAIT_START;
          end
        end
        WAIT_START: begin
          // Wait for the transmitter to acknowledge by raising busy
          if (Tx_Busy) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!Tx_Busy) begin
            if (cnt_q == LAST_IDX) begin
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q + CW'(1);
              state_q <= LOAD;
            end
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Tx_Data       = tx_data_q;
  assign Tx_Data_Valid = tx_valid_q;
  assign Ready         = ready_q;

`ifdef ALU_SER_OVERRUN_FLAG_EN
  logic overrun_q;

  // Sticky flag: a result arrived while the previous one was still in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overrun_q <= 1'b0;
    end else if (ALU_Out_Valid && !ready_q) begin
      overrun_q <= 1'b1;
    end
  end

  assign Overrun = overrun_q;
`endif

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench for alu_result_serializer: directed scenarios followed
// by randomized words, checked against a byte-queue reference model and a
// simple UART busy model.
module tb_alu_result_serializer;

  localparam int RW = 16;
  localparam int BW = 8;
  localparam int NB = RW / BW;

  logic          CLK = 1'b0;
  logic          RST;
  logic [RW-1:0] ALU_Out;
  logic          ALU_Out_Valid;
  logic          Tx_Busy;
  logic [BW-1:0] Tx_Data;
  logic          Tx_Data_Valid;
  logic          Ready;
`ifdef ALU_SER_OVERRUN_FLAG_EN
  logic          Overrun;
`endif

  alu_result_serializer #(
    .Result_width(RW),
    .Byte_width  (BW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ALU_Out      (ALU_Out),
    .ALU_Out_Valid(ALU_Out_Valid),
    .Tx_Busy      (Tx_Busy),
    .Tx_Data      (Tx_Data),
    .Tx_Data_Valid(Tx_Data_Valid),
    .Ready        (Ready)
`ifdef ALU_SER_OVERRUN_FLAG_EN
    ,
    .Overrun      (Overrun)
`endif
  );

  always #5 CLK = ~CLK;

  int            n_tests   = 0;
  int            n_fail    = 0;
  int            cycle     = 0;
  int            busy_cnt  = 0;
  int            busy_len  = 10;
  bit            busy_force = 1'b0;
  bit            exp_ovr   = 1'b0;
  logic [BW-1:0] got   [$];
  int            pc    [$];
  logic [BW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_ovr(input string tag);
`ifdef ALU_SER_OVERRUN_FLAG_EN
    check(tag, 32'(Overrun), 32'(exp_ovr));
`else
    n_tests = n_tests + 0;
    if (tag.len() == 0) n_tests = n_tests + 0;
`endif
  endtask

  // One clock: sample outputs on the falling edge, then advance the UART
  // busy model and drop the one-cycle valid strobe after the rising edge.
  task automatic tick();
    bit pulsed;
    pulsed = 1'b0;
    @(negedge CLK);
    if (Tx_Data_Valid === 1'b1) begin
      check("no_pulse_while_busy", 32'(Tx_Busy), 32'd0);
      got.push_back(Tx_Data);
      pc.push_back(cycle);
      pulsed = 1'b1;
    end
    @(posedge CLK);
    #1;
    cycle++;
    if (busy_cnt > 0) busy_cnt--;
    if (pulsed) busy_cnt = busy_len;
    Tx_Busy       = busy_force || (busy_cnt != 0);
    ALU_Out_Valid = 1'b0;
  endtask

  // Send one word and check every byte, the latency, and the Ready timing.
  task automatic run_word(input logic [RW-1:0] word, input int hold,
                          input bit overlap, input logic [RW-1:0] junk,
                          input bit end_junk);
    int            vcyc;
    int            first_exp;
    int            budget;
    logic [RW-1:0] w;
    for (int i = 0; i < NB; i++) begin
      w = word >> (BW * i);
      exp_q.push_back(w[BW-1:0]);
    end
    got.delete();
    pc.delete();
    if (hold > 0) begin
      busy_force = 1'b1;
      Tx_Busy    = 1'b1;
    end
    vcyc          = cycle;
    ALU_Out       = word;
    ALU_Out_Valid = 1'b1;
    tick();
    check("ready_drop", 32'(Ready), 32'd0);
    first_exp = vcyc + 2;
    if (hold > 0) begin
      repeat (hold - 1) tick();
      check("hold_no_pulse", got.size(), 32'd0);
      busy_force = 1'b0;
      Tx_Busy    = (busy_cnt != 0);
      first_exp  = cycle + 1;
    end
    if (overlap) begin
      tick();
      tick();
      ALU_Out       = junk;
      ALU_Out_Valid = 1'b1;
      exp_ovr       = 1'b1;
      tick();
    end
    budget = 0;
    while (got.size() < NB && budget < 400) begin
      tick();
      budget++;
    end
    check("byte_count", got.size(), NB);
    if (pc.size() > 0) check("first_latency", pc[0], first_exp);
    repeat (busy_len) tick();
    check("ready_low_at_done", 32'(Ready), 32'd0);
    if (got.size() > 0) check("data_held", 32'(Tx_Data), 32'(got[got.size()-1]));
    if (end_junk) begin
      ALU_Out       = junk;
      ALU_Out_Valid = 1'b1;
      exp_ovr       = 1'b1;
    end
    tick();
    check("ready_high_after_done", 32'(Ready), 32'd1);
    for (int i = 0; i < NB; i++) begin
      if (i < got.size()) check($sformatf("byte%0d_of_%04h", i, word), 32'(got[i]), 32'(exp_q[i]));
    end
    check_ovr("overrun");
    got.delete();
    pc.delete();
    exp_q.delete();
  endtask

  initial begin
    int budget;

    // Reset, then idle
    RST           = 1'b0;
    ALU_Out       = '0;
    ALU_Out_Valid = 1'b0;
    Tx_Busy       = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_valid", 32'(Tx_Data_Valid), 32'd0);
    check("rst_data", 32'(Tx_Data), 32'd0);
    check_ovr("rst_overrun");
    RST = 1'b1;
    tick();
    tick();
    check("idle_ready", 32'(Ready), 32'd1);
    check("idle_no_pulse", got.size(), 32'd0);

    // Basic send, busy held at start, overlapping request
    busy_len = 10;
    run_word(16'hA55A, 0, 1'b0, 16'h0000, 1'b0);
    run_word(16'h1234, 5, 1'b0, 16'h0000, 1'b0);
    run_word(16'h00C3, 0, 1'b1, 16'hFFFF, 1'b0);

    // Reset mid-transfer while byte 0 is being shifted out
    ALU_Out       = 16'h7E81;
    ALU_Out_Valid = 1'b1;
    tick();
    budget = 0;
    while (got.size() < 1 && budget < 100) begin
      tick();
      budget++;
    end
    check("mid_byte0_count", got.size(), 32'd1);
    if (got.size() > 0) check("mid_byte0", 32'(got[0]), 32'h81);
    repeat (3) tick();
    RST = 1'b0;
    #1;
    check("midrst_ready", 32'(Ready), 32'd1);
    check("midrst_valid", 32'(Tx_Data_Valid), 32'd0);
    check("midrst_data", 32'(Tx_Data), 32'd0);
    exp_ovr = 1'b0;
    check_ovr("midrst_overrun");
    busy_cnt = 0;
    Tx_Busy  = 1'b0;
    got.delete();
    pc.delete();
    exp_q.delete();
    tick();
    tick();
    RST = 1'b1;
    tick();
    check("post_rst_ready", 32'(Ready), 32'd1);
    check("post_rst_no_pulse", got.size(), 32'd0);
    run_word(16'h0F0F, 0, 1'b0, 16'h0000, 1'b0);

    // Back-to-back, plus a strobe on the completing cycle that must be dropped
    run_word(16'h8001, 0, 1'b0, 16'h0000, 1'b0);
    run_word(16'h5511, 0, 1'b0, 16'hDEAD, 1'b1);
    run_word(16'h8001, 0, 1'b0, 16'h0000, 1'b0);

    // Randomized words with random busy lengths, holds and dropped strobes
    for (int t = 0; t < 12; t++) begin
      logic [RW-1:0] w;
      logic [RW-1:0] j;
      int            h;
      w        = RW'($urandom);
      j        = RW'($urandom);
      busy_len = int'($urandom_range(1, 6));
      h        = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 4)) : 0;
      run_word(w, h, 1'($urandom_range(0, 1)), j, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end

    // Nothing further may be transmitted once idle
    repeat (30) tick();
    check("final_no_pulse", got.size(), 32'd0);
    check("final_ready", 32'(Ready), 32'd1);
    check_ovr("final_overrun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Sits directly downstream of the ALU output mux. Captures the ALU result word on its valid strobe and splits it into bytes, least-significant byte first.
- Hands each byte to the UART transmitter using a valid/busy handshake.
- Provides Ready back to the system controller so a new ALU operation is issued only once the previous result has been fully sent.

Parameters:
- Result_width, 16, width of the ALU result word (must be a multiple of Byte_width).
- Byte_width, 8, width of one UART TX payload.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- ALU_Out  input  Result_width  result word from the ALU output mux.
- ALU_Out_Valid  input  1  one-cycle strobe; ALU_Out is valid in this cycle.
- Tx_Busy  input  1  UART TX busy; high while a frame is being shifted out.
- Tx_Data  output  Byte_width  byte presented to UART TX.
- Tx_Data_Valid  output  1  one-cycle strobe requesting UART TX to start a frame.
- Ready  output  1  high when a new result can be accepted.

Behaviour:
- Reset (RST low, asynchronous): state = IDLE, holding register = 0, byte counter = 0, Tx_Data = 0, Tx_Data_Valid = 0, Ready = 1.
- Number of bytes: NB = Result_width / Byte_width (2 at defaults). The byte counter is ceil(log2(NB)) bits wide, minimum 1.
- States: IDLE, LOAD, WAIT_START, WAIT_DONE.
- IDLE:
  - Ready = 1.
  - When ALU_Out_Valid = 1: capture ALU_Out into the holding register, set counter = 0, Ready drops next cycle, go to LOAD.
- LOAD:
  - If Tx_Busy = 0: Tx_Data = holding[counter*Byte_width +: Byte_width], Tx_Data_Valid = 1 for exactly one cycle, go to WAIT_START.
  - If Tx_Busy = 1: stay in LOAD and do not pulse.
- WAIT_START:
  - Tx_Data_Valid = 0 and Tx_Data is held.
  - When Tx_Busy = 1, go to WAIT_DONE.
- WAIT_DONE:
  - Tx_Data is held until Tx_Busy = 0.
  - On Tx_Busy = 0: if counter == NB-1, go to IDLE (Ready = 1 next cycle). Otherwise counter += 1 and go to LOAD.
- Ready is registered: 1 only in IDLE.
- Latency: ALU_Out_Valid in cycle N gives the first Tx_Data_Valid no earlier than cycle N+2 (one cycle into LOAD, one cycle to the registered strobe), when Tx_Busy = 0.
- Tx_Data_Valid never pulses while Tx_Busy = 1. There is at most one pulse per byte.
- ALU_Out_Valid while Ready = 0: ignored. The holding register is unchanged and the in-flight transfer is not disturbed.
- ALU_Out_Valid in the same cycle the last byte completes (WAIT_DONE to IDLE transition): ignored, because Ready is still 0 in that cycle.
- Reset mid-transfer: all state clears immediately, Tx_Data_Valid drops, and the partially sent word is discarded.
- Tx_Busy stuck at 0 after a pulse: the block remains in WAIT_START. There is no timeout; UART TX guarantees that Busy rises.

Optional Feature:
- Macro: ALU_SER_OVERRUN_FLAG_EN.
- Defined: adds output port Overrun (1 bit, reset 0).
  - Sets to 1 on any cycle where ALU_Out_Valid = 1 and Ready = 0.
  - Sticky; cleared only by reset.
  - The dropped result is still ignored as above.
- Undefined: no Overrun port and no associated logic. Behaviour is otherwise identical.

Test Plan:
- Reset, then idle: RST low then high, inputs at 0 -> Ready = 1, Tx_Data_Valid = 0, Tx_Data = 0x00.
- Basic send: ALU_Out = 0xA55A, one Valid pulse, Tx_Busy model asserts 1 cycle after each pulse for 10 cycles -> Tx_Data 0x5A with one pulse, then 0xA5 with one pulse; Ready returns to 1 one cycle after Busy falls on the second byte.
- Busy held at start: Tx_Busy = 1 when Valid arrives with ALU_Out = 0x1234, then released 5 cycles later -> no pulse while Busy = 1; the first pulse carries 0x34 in the cycle after Busy falls.
- Overlapping request: second Valid with 0xFFFF during the transfer of 0x00C3 -> bytes sent are 0xC3 then 0x00 only. With ALU_SER_OVERRUN_FLAG_EN defined, Overrun = 1 from the next cycle.
- Reset mid-transfer: assert RST while in WAIT_DONE of byte 0 -> outputs return to reset values immediately. A new Valid with 0x0F0F after release sends 0x0F, 0x0F.
- Back-to-back: Valid reasserted in the first cycle Ready = 1 after completion, with 0x8001 -> bytes 0x01, 0x80 are sent with no lost or duplicated pulses.
